// File: rtl/mix_pkg.sv
// Shared constants and helpers for the mix slot datapath.
// The saturating-add helper is only called when MIX_COMB_SAT_EN is defined.
package mix_pkg;

    localparam int MIX_WIDTH_DEFAULT = 8;
    localparam int MIX_MAX_WIDTH     = 64;

    // Operands are zero-extended to 64 bits; width selects the saturation ceiling (1..64).
    function automatic logic [MIX_MAX_WIDTH-1:0] mix_sat_add(
        input logic [MIX_MAX_WIDTH-1:0] x,
        input logic [MIX_MAX_WIDTH-1:0] y,
        input int unsigned              width
    );
        logic [MIX_MAX_WIDTH:0] sum_ext;
        logic [MIX_MAX_WIDTH:0] max_ext;
        sum_ext = {1'b0, x} + {1'b0, y};
        max_ext = ({{MIX_MAX_WIDTH{1'b0}}, 1'b1} << width) - 1'b1;
        if (sum_ext > max_ext) begin
            return max_ext[MIX_MAX_WIDTH-1:0];
        end
        return sum_ext[MIX_MAX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mix_adder.sv
// Unsigned WIDTH-bit adder for the mix slot; wraps by default and
// saturates to all ones when MIX_COMB_SAT_EN is defined (WIDTH <= 64).
module mix_adder
    import mix_pkg::*;
#(
    parameter int WIDTH = MIX_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] sum
);

`ifdef MIX_COMB_SAT_EN
    logic [MIX_MAX_WIDTH-1:0] sat_full;

    assign sat_full = mix_sat_add(MIX_MAX_WIDTH'(op_a), MIX_MAX_WIDTH'(op_b), WIDTH);
    assign sum      = sat_full[WIDTH-1:0];
`else
    // Carry-out is intentionally dropped: result is the sum modulo 2^WIDTH.
    assign sum = op_a + op_b;
`endif

endmodule

// File: rtl/mix_core.sv
// Glue stage for the mix slot: one data register, an adder and two select muxes.
// MIX_COMB_SAT_EN switches comb_out from wrap-around to saturating addition.
module mix_core
    import mix_pkg::*;
#(
    parameter int WIDTH = MIX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] comb_in,
    input  logic [WIDTH-1:0] comb_add,
    input  logic [WIDTH-1:0] a,
    input  logic             sel,
    input  logic             b,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] comb_out,
    output logic [WIDTH-1:0] out,
    output logic             c
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    // rst is active-low and only takes effect on a rising edge.
    assign data_next = rst ? data_in : '0;

    always_ff @(posedge clk) begin
        data_reg <= data_next;
    end

    assign data_out = data_reg;

    mix_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .op_a (comb_in),
        .op_b (comb_add),
        .sum  (comb_out)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_out_mux
            assign out[gi] = sel ? a[gi] : data_reg[gi];
        end
    endgenerate

    assign c = sel & b;

endmodule

// File: tb/tb_mix_core.sv
// Directed plus short random check of mix_core (WIDTH=8).
// Expected comb_out follows MIX_COMB_SAT_EN when the bench is built with it.
module tb_mix_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic [W-1:0] comb_in;
    logic [W-1:0] comb_add;
    logic [W-1:0] a;
    logic         sel;
    logic         b;
    logic [W-1:0] data_out;
    logic [W-1:0] comb_out;
    logic [W-1:0] out;
    logic         c;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_reg;

    mix_core #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .comb_in  (comb_in),
        .comb_add (comb_add),
        .a        (a),
        .sel      (sel),
        .b        (b),
        .data_out (data_out),
        .comb_out (comb_out),
        .out      (out),
        .c        (c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
`ifdef MIX_COMB_SAT_EN
        if (s[W]) return {W{1'b1}};
`endif
        return s[W-1:0];
    endfunction

    // Advance one rising edge, update the register model, return at negedge+1.
    task automatic tick();
        logic [W-1:0] nxt;
        nxt = rst ? data_in : '0;
        @(posedge clk);
        #1;
        exp_reg = nxt;
        $display("edge t=%0t rst=%0b data_in=%0h -> data_out=%0h (exp %0h)",
                 $time, rst, data_in, data_out, exp_reg);
        chk("data_out", data_out, exp_reg);
        @(negedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag);
        chk({tag, "_comb_out"}, comb_out, model_add(comb_in, comb_add));
        chk({tag, "_out"}, out, sel ? a : exp_reg);
        chk({tag, "_c"}, {7'd0, c}, {7'd0, sel & b});
    endtask

    initial begin
        rst = 1'b0; data_in = 8'h5A; comb_in = 8'd6; comb_add = 8'd34;
        a = 8'd0; sel = 1'b0; b = 1'b0;
        #1;
        chk("add_6_34", comb_out, 8'd40);

        // Reset edge
        tick();
        chk("reset_data_out", data_out, 8'h00);
        chk("reset_out", out, 8'h00);

        // Register load
        rst = 1'b1; data_in = 8'h00;
        tick();
        chk("load_00", data_out, 8'h00);
        data_in = 8'h3C;
        #1;
        chk("load_hold_before_edge", data_out, 8'h00);
        tick();
        chk("load_3c", data_out, 8'h3C);

        // Adder wrap / saturate boundaries
        comb_in = 8'd200; comb_add = 8'd100;
        #1;
`ifdef MIX_COMB_SAT_EN
        chk("add_200_100", comb_out, 8'd255);
`else
        chk("add_200_100", comb_out, 8'd44);
`endif
        comb_in = 8'd128; comb_add = 8'd128;
        #1;
`ifdef MIX_COMB_SAT_EN
        chk("add_128_128", comb_out, 8'd255);
`else
        chk("add_128_128", comb_out, 8'd0);
`endif
        comb_in = 8'd255; comb_add = 8'd0;
        #1;
        chk("add_255_0", comb_out, 8'd255);

        // c mux
        sel = 1'b1; b = 1'b0; #1;
        chk("c_sel1_b0", {7'd0, c}, 8'd0);
        b = 1'b1; #1;
        chk("c_sel1_b1", {7'd0, c}, 8'd1);
        sel = 1'b0; #1;
        chk("c_sel0_b1", {7'd0, c}, 8'd0);

        // out mux
        sel = 1'b1; a = 8'd86; #1;
        chk("out_a86", out, 8'd86);
        a = 8'd75; #1;
        chk("out_a75", out, 8'd75);
        sel = 1'b0; #1;
        chk("out_reg3c", out, 8'h3C);

        // Mid-stream reset: clears on first low edge, reloads once released
        data_in = 8'hA5; rst = 1'b0;
        tick();
        chk("midrst_clear", data_out, 8'h00);
        chk("midrst_out", out, 8'h00);
        rst = 1'b1;
        tick();
        chk("midrst_reload", data_out, 8'hA5);

        // Random soak with occasional reset pulses
        for (int i = 0; i < 30; i++) begin
            data_in  = W'($urandom);
            comb_in  = W'($urandom);
            comb_add = W'($urandom);
            a        = W'($urandom);
            sel      = 1'($urandom);
            b        = 1'($urandom);
            rst      = ($urandom_range(0, 5) != 0);
            #1;
            $display("soak %0d: rst=%0b sel=%0b b=%0b a=%0h in=%0h ci=%0h ca=%0h",
                     i, rst, sel, b, a, data_in, comb_in, comb_add);
            check_comb("soak");
            tick();
            check_comb("soak_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
